// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (CPU/host) memory arbiter with CPU priority and a host starvation guard
// Single-cycle grant, one-cycle ack; read data bypasses into a per-port hold register.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_ack,
  output logic [31:0]   cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  output logic          host_gnt,
  output logic          host_ack,
  output logic [31:0]   host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_HOST = 2'd2;

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [1:0]    owner_q, owner_d;
  logic          rd_q, rd_d;
  logic [31:0]   cpu_hold_q, cpu_hold_d;
  logic [31:0]   host_hold_q, host_hold_d;
  logic          host_win;
  logic          cpu_rd_ack;
  logic          host_rd_ack;

  always_comb begin
    host_win  = host_req && (!cpu_req || (starve_cnt_q == LIMIT));
    cpu_gnt   = !rst && cpu_req && !host_win;
    host_gnt  = !rst && host_win;
    cpu_stall = !rst && cpu_req && !cpu_gnt;

    mem_en    = cpu_gnt || host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // The counter only runs while the host is actually being passed over; it saturates at LIMIT.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!host_req || host_gnt) begin
      starve_cnt_d = '0;
    end else if (cpu_gnt && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    rd_d    = 1'b0;
    if (cpu_gnt) begin
      owner_d = OWN_CPU;
      rd_d    = !cpu_we;
    end else if (host_gnt) begin
      owner_d = OWN_HOST;
      rd_d    = !host_we;
    end
  end

  // Memory data only exists in the ack cycle, so it is forwarded then and captured for later cycles.
  always_comb begin
    cpu_ack     = !rst && (owner_q == OWN_CPU);
    host_ack    = !rst && (owner_q == OWN_HOST);
    cpu_rd_ack  = cpu_ack && rd_q;
    host_rd_ack = host_ack && rd_q;
    cpu_hold_d  = cpu_rd_ack ? mem_rdata : cpu_hold_q;
    host_hold_d = host_rd_ack ? mem_rdata : host_hold_q;
    cpu_rdata   = rst ? 32'd0 : cpu_hold_d;
    host_rdata  = rst ? 32'd0 : host_hold_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      owner_q      <= OWN_NONE;
      rd_q         <= 1'b0;
      cpu_hold_q   <= '0;
      host_hold_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      rd_q         <= rd_d;
      cpu_hold_q   <= cpu_hold_d;
      host_hold_q  <= host_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector table plus randomized scoreboard for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int AW           = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, host_req, host_we;
  logic [AW-1:0] cpu_addr, host_addr;
  logic [31:0]   cpu_wdata, host_wdata;
  logic          cpu_gnt, cpu_stall, cpu_ack, host_gnt, host_ack;
  logic [31:0]   cpu_rdata, host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  // Synchronous RAM device: unwritten words read as init_word, idle cycles return garbage.
  logic [31:0] mem [1024];
  bit          wr  [1024];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr[mem_addr]  <= 1'b1;
    end
    if (mem_en && !mem_we) mem_rdata <= wr[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
    else                   mem_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst, creq, cwe; logic [AW-1:0] caddr; logic [31:0] cwd;
    logic hreq, hwe;      logic [AW-1:0] haddr; logic [31:0] hwd;
    logic cg, hg, ca, ha; logic [31:0] crd, hrd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic cq, input logic cw, input logic [AW-1:0] ca_,
                              input logic [31:0] cd, input logic hq, input logic hw, input logic [AW-1:0] ha_,
                              input logic [31:0] hd, input logic eg_c, input logic eg_h, input logic ea_c,
                              input logic ea_h, input logic [31:0] ercd, input logic [31:0] erhd);
    vec_t v;
    v.rst = r; v.creq = cq; v.cwe = cw; v.caddr = ca_; v.cwd = cd;
    v.hreq = hq; v.hwe = hw; v.haddr = ha_; v.hwd = hd;
    v.cg = eg_c; v.hg = eg_h; v.ca = ea_c; v.ha = ea_h; v.crd = ercd; v.hrd = erhd;
    return v;
  endfunction

  logic [31:0] shadow [1024];
  logic        cp, hp, pa_c, pa_h, pa_rd, ec, eh;
  logic [31:0] pa_data, exp_crd, exp_hrd;
  int          cwait, hwait;

  initial begin
    logic [31:0] d;
    d = 32'hDEADBEEF;
    rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;

    //          rst cq cw addr    cwd           hq hw addr    hwd           cg hg ca ha crd                 hrd
    tbl.push_back(mk(1, 1, 0, 10'h000, 0,            1, 0, 10'h000, 0,            0, 0, 0, 0, 0,                  0));
    tbl.push_back(mk(0, 1, 1, 10'h005, d,            0, 0, 10'h000, 0,            1, 0, 0, 0, 0,                  0));
    tbl.push_back(mk(0, 1, 0, 10'h005, 0,            0, 0, 10'h000, 0,            1, 0, 1, 0, 0,                  0));
    tbl.push_back(mk(0, 0, 0, 10'h000, 0,            0, 0, 10'h000, 0,            0, 0, 1, 0, d,                  0));
    tbl.push_back(mk(0, 0, 0, 10'h000, 0,            0, 0, 10'h000, 0,            0, 0, 0, 0, d,                  0));
    tbl.push_back(mk(0, 1, 0, 10'h010, 0,            0, 0, 10'h000, 0,            1, 0, 0, 0, d,                  0));
    tbl.push_back(mk(0, 0, 0, 10'h000, 0,            1, 0, 10'h020, 0,            0, 1, 1, 0, init_word(10'h010), 0));
    tbl.push_back(mk(0, 0, 0, 10'h000, 0,            0, 0, 10'h000, 0,            0, 0, 0, 1, init_word(10'h010), init_word(10'h020)));
    tbl.push_back(mk(0, 0, 0, 10'h000, 0,            1, 0, 10'h030, 0,            0, 1, 0, 0, init_word(10'h010), init_word(10'h020)));
    tbl.push_back(mk(0, 0, 0, 10'h000, 0,            1, 0, 10'h031, 0,            0, 1, 0, 1, init_word(10'h010), init_word(10'h030)));
    tbl.push_back(mk(0, 0, 0, 10'h000, 0,            1, 0, 10'h032, 0,            0, 1, 0, 1, init_word(10'h010), init_word(10'h031)));
    tbl.push_back(mk(0, 1, 0, 10'h040, 0,            1, 0, 10'h050, 0,            1, 0, 0, 1, init_word(10'h010), init_word(10'h032)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 10'h040, 0,          1, 0, 10'h050, 0,            1, 0, 1, 0, init_word(10'h040), init_word(10'h032)));
    tbl.push_back(mk(0, 1, 0, 10'h040, 0,            1, 0, 10'h050, 0,            0, 1, 1, 0, init_word(10'h040), init_word(10'h032)));
    tbl.push_back(mk(0, 1, 0, 10'h040, 0,            1, 0, 10'h051, 0,            1, 0, 0, 1, init_word(10'h040), init_word(10'h050)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 10'h040, 0,          1, 0, 10'h051, 0,            1, 0, 1, 0, init_word(10'h040), init_word(10'h050)));
    tbl.push_back(mk(0, 1, 0, 10'h040, 0,            1, 0, 10'h051, 0,            0, 1, 1, 0, init_word(10'h040), init_word(10'h050)));
    tbl.push_back(mk(0, 0, 0, 10'h000, 0,            0, 0, 10'h000, 0,            0, 0, 0, 1, init_word(10'h040), init_word(10'h051)));
    tbl.push_back(mk(0, 1, 0, 10'h010, 0,            0, 0, 10'h000, 0,            1, 0, 0, 0, init_word(10'h040), init_word(10'h051)));
    tbl.push_back(mk(1, 1, 0, 10'h010, 0,            1, 0, 10'h000, 0,            0, 0, 0, 0, 0,                  0));
    tbl.push_back(mk(0, 0, 0, 10'h000, 0,            0, 0, 10'h000, 0,            0, 0, 0, 0, 0,                  0));
    tbl.push_back(mk(0, 1, 1, 10'h060, 32'h11111111, 1, 1, 10'h061, 32'h22222222, 1, 0, 0, 0, 0,                  0));
    tbl.push_back(mk(0, 0, 0, 10'h000, 0,            0, 0, 10'h000, 0,            0, 0, 1, 0, 0,                  0));
    tbl.push_back(mk(0, 0, 0, 10'h000, 0,            1, 0, 10'h061, 0,            0, 1, 0, 0, 0,                  0));
    tbl.push_back(mk(0, 1, 0, 10'h060, 0,            0, 0, 10'h000, 0,            1, 0, 0, 1, 0,                  init_word(10'h061)));
    tbl.push_back(mk(0, 0, 0, 10'h000, 0,            0, 0, 10'h000, 0,            0, 0, 1, 0, 32'h11111111,       init_word(10'h061)));

    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      rst = tbl[i].rst; cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; cpu_addr = tbl[i].caddr;
      cpu_wdata = tbl[i].cwd; host_req = tbl[i].hreq; host_we = tbl[i].hwe;
      host_addr = tbl[i].haddr; host_wdata = tbl[i].hwd;
      @(negedge clk);
      chk($sformatf("v%0d cpu_gnt", i),    32'(cpu_gnt),   32'(tbl[i].cg));
      chk($sformatf("v%0d host_gnt", i),   32'(host_gnt),  32'(tbl[i].hg));
      chk($sformatf("v%0d cpu_ack", i),    32'(cpu_ack),   32'(tbl[i].ca));
      chk($sformatf("v%0d host_ack", i),   32'(host_ack),  32'(tbl[i].ha));
      chk($sformatf("v%0d cpu_stall", i),  32'(cpu_stall), 32'(tbl[i].creq && !tbl[i].cg && !tbl[i].rst));
      chk($sformatf("v%0d mem_en", i),     32'(mem_en),    32'(tbl[i].cg || tbl[i].hg));
      chk($sformatf("v%0d cpu_rdata", i),  cpu_rdata,      tbl[i].crd);
      chk($sformatf("v%0d host_rdata", i), host_rdata,     tbl[i].hrd);
    end

    // Randomized phase: requests held until granted, scored against a word-level shadow memory.
    for (int i = 0; i < 1024; i++) shadow[i] = init_word(10'(i));
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 0; host_req = 0;
    cp = 0; hp = 0; pa_c = 0; pa_h = 0; pa_rd = 0; pa_data = 0;
    exp_crd = 0; exp_hrd = 0; cwait = 0; hwait = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      if (!cp && $urandom_range(0, 99) < 60) begin
        cp = 1; cwait = 0;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 10'(10'h100 + 10'($urandom_range(0, 15)));
        cpu_wdata = $urandom;
      end
      if (!hp && $urandom_range(0, 99) < 50) begin
        hp = 1; hwait = 0;
        host_we = 1'($urandom_range(0, 1));
        host_addr = 10'(10'h100 + 10'($urandom_range(0, 15)));
        host_wdata = $urandom;
      end
      cpu_req = cp; host_req = hp;
      @(negedge clk);
      // The host wins once it has been passed over STARVE_LIMIT times, or whenever the CPU is idle.
      eh = hp && (!cp || hwait == STARVE_LIMIT);
      ec = cp && !eh;
      chk("rnd cpu_gnt",   32'(cpu_gnt),   32'(ec));
      chk("rnd host_gnt",  32'(host_gnt),  32'(eh));
      chk("rnd cpu_stall", 32'(cpu_stall), 32'(cp && !ec));
      chk("rnd mem_en",    32'(mem_en),    32'(ec || eh));
      chk("rnd mem_we",    32'(mem_we),    32'(ec ? cpu_we : eh ? host_we : 1'b0));
      chk("rnd mem_addr",  32'(mem_addr),  32'(ec ? cpu_addr : eh ? host_addr : 10'd0));
      chk("rnd mem_wdata", mem_wdata,      ec ? cpu_wdata : eh ? host_wdata : 32'd0);
      chk("rnd cpu_ack",   32'(cpu_ack),   32'(pa_c));
      chk("rnd host_ack",  32'(host_ack),  32'(pa_h));
      if (pa_c && pa_rd) exp_crd = pa_data;
      if (pa_h && pa_rd) exp_hrd = pa_data;
      chk("rnd cpu_rdata",  cpu_rdata,  exp_crd);
      chk("rnd host_rdata", host_rdata, exp_hrd);
      pa_c = ec; pa_h = eh;
      if (ec) begin
        pa_rd = !cpu_we; pa_data = shadow[cpu_addr];
        if (cpu_we) shadow[cpu_addr] = cpu_wdata;
        chk("rnd cpu_wait_bound", 32'(cwait + 1 <= STARVE_LIMIT + 1), 32'd1);
        cp = 0;
      end else if (cp) cwait++;
      if (eh) begin
        pa_rd = !host_we; pa_data = shadow[host_addr];
        if (host_we) shadow[host_addr] = host_wdata;
        chk("rnd host_wait_bound", 32'(hwait + 1 <= STARVE_LIMIT + 1), 32'd1);
        hp = 0;
      end else if (hp) hwait++;
      if (cwait > STARVE_LIMIT + 1 || hwait > STARVE_LIMIT + 1) begin
        chk("rnd wait_expired", 32'(cwait > hwait ? cwait : hwait), 32'(STARVE_LIMIT + 1));
        cwait = 0; hwait = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
